// File: rtl/jtag_tap_rsp_if.sv
// Single-beat bus request/response port between the JTAG TAP responder and the debug fabric.
interface jtag_tap_rsp_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_wr, req_size, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_size, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/jtag_tap_rsp.sv
// JTAG TAP responder: oversampled pins, 1149.1 TAP controller, 4-bit IR and
// an ACCESS data register that turns shifted words into single-beat bus requests.
module jtag_tap_rsp #(
  parameter logic [31:0] IDCODE      = 32'h1BA0_C001,
  parameter int          SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic tck,
  input  logic tms,
  input  logic tdi,
  input  logic jtrst,
  output logic tdo,
  jtag_tap_rsp_if.master bus
);

  localparam logic [3:0] IR_IDCODE  = 4'b0001;
  localparam logic [3:0] IR_ACCESS  = 4'b0010;
  localparam logic [3:0] IR_STATUS  = 4'b0011;
  localparam logic [3:0] IR_CAPTURE = 4'b0101;

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
  } tap_state_e;

  logic [SYNC_STAGES-1:0] tckSync_q, tmsSync_q, tdiSync_q, jtrstSync_q;
  logic tckS, tmsS, tdiS, jtrstS;
  logic tckPrev_q, tckRise_q, tckFall_q;

  tap_state_e  state_q;
  logic [3:0]  ir_q, irShift_q;
  logic [66:0] dr_q, dr_d;
  logic        tdo_q;

  logic        reqValid_q, reqWr_q;
  logic [1:0]  reqSize_q;
  logic [31:0] reqAddr_q, reqWdata_q;
  logic        busy_q, err_q, overrun_q;
  logic [31:0] lastRdata_q, lastAddr_q;

  logic tapStep, capDr, shDr, updDr, capIr, shIr, updIr;
  logic accessUpd, rspDone, busyEff, issueReq, badSize, overrunSet, overrunClr;

  always_ff @(posedge clk) begin
    if (reset) begin
      tckSync_q   <= '0;
      tmsSync_q   <= '0;
      tdiSync_q   <= '0;
      jtrstSync_q <= '1;
      tckPrev_q   <= 1'b0;
      tckRise_q   <= 1'b0;
      tckFall_q   <= 1'b0;
    end else begin
      tckSync_q   <= {tckSync_q[SYNC_STAGES-2:0], tck};
      tmsSync_q   <= {tmsSync_q[SYNC_STAGES-2:0], tms};
      tdiSync_q   <= {tdiSync_q[SYNC_STAGES-2:0], tdi};
      jtrstSync_q <= {jtrstSync_q[SYNC_STAGES-2:0], jtrst};
      tckPrev_q   <= tckS;
      tckRise_q   <= tckS & ~tckPrev_q;
      tckFall_q   <= ~tckS & tckPrev_q;
    end
  end

  assign tckS   = tckSync_q[SYNC_STAGES-1];
  assign tmsS   = tmsSync_q[SYNC_STAGES-1];
  assign tdiS   = tdiSync_q[SYNC_STAGES-1];
  assign jtrstS = jtrstSync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset || !jtrstS) begin
      state_q <= TLR;
    end else if (tckRise_q) begin
      case (state_q)
        TLR:      state_q <= tmsS ? TLR    : RTI;
        RTI:      state_q <= tmsS ? SEL_DR : RTI;
        SEL_DR:   state_q <= tmsS ? SEL_IR : CAP_DR;
        CAP_DR:   state_q <= tmsS ? EX1_DR : SH_DR;
        SH_DR:    state_q <= tmsS ? EX1_DR : SH_DR;
        EX1_DR:   state_q <= tmsS ? UPD_DR : PAUSE_DR;
        PAUSE_DR: state_q <= tmsS ? EX2_DR : PAUSE_DR;
        EX2_DR:   state_q <= tmsS ? UPD_DR : SH_DR;
        UPD_DR:   state_q <= tmsS ? SEL_DR : RTI;
        SEL_IR:   state_q <= tmsS ? TLR    : CAP_IR;
        CAP_IR:   state_q <= tmsS ? EX1_IR : SH_IR;
        SH_IR:    state_q <= tmsS ? EX1_IR : SH_IR;
        EX1_IR:   state_q <= tmsS ? UPD_IR : PAUSE_IR;
        PAUSE_IR: state_q <= tmsS ? EX2_IR : PAUSE_IR;
        EX2_IR:   state_q <= tmsS ? UPD_IR : SH_IR;
        UPD_IR:   state_q <= tmsS ? SEL_DR : RTI;
        default:  state_q <= TLR;
      endcase
    end
  end

  // Capture/shift act on the rise taken while in the state; update acts on the rise that enters Upd*.
  assign tapStep = tckRise_q & jtrstS;
  assign capDr   = tapStep && (state_q == CAP_DR);
  assign shDr    = tapStep && (state_q == SH_DR);
  assign updDr   = tapStep && tmsS && ((state_q == EX1_DR) || (state_q == EX2_DR));
  assign capIr   = tapStep && (state_q == CAP_IR);
  assign shIr    = tapStep && (state_q == SH_IR);
  assign updIr   = tapStep && tmsS && ((state_q == EX1_IR) || (state_q == EX2_IR));

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q      <= IR_IDCODE;
      irShift_q <= 4'b0000;
    end else if (!jtrstS || state_q == TLR) begin
      ir_q <= IR_IDCODE;
    end else begin
      if (capIr) begin
        irShift_q <= IR_CAPTURE;
      end else if (shIr) begin
        irShift_q <= {tdiS, irShift_q[3:1]};
      end
      if (updIr) begin
        ir_q <= irShift_q;
      end
    end
  end

  always_comb begin
    dr_d       = dr_q;
    overrunClr = 1'b0;
    if (capDr) begin
      case (ir_q)
        IR_IDCODE: dr_d = {35'd0, IDCODE};
        IR_ACCESS: dr_d = {2'b00, err_q, lastRdata_q, lastAddr_q};
        IR_STATUS: begin
          dr_d       = {64'd0, overrun_q, err_q, busy_q};
          overrunClr = 1'b1;
        end
        default:   dr_d = '0;
      endcase
    end else if (shDr) begin
      case (ir_q)
        IR_IDCODE: dr_d = {35'd0, tdiS, dr_q[31:1]};
        IR_ACCESS: dr_d = {tdiS, dr_q[66:1]};
        IR_STATUS: dr_d = {64'd0, tdiS, dr_q[2:1]};
        default:   dr_d = {66'd0, tdiS};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dr_q  <= '0;
      tdo_q <= 1'b0;
    end else begin
      dr_q <= dr_d;
      if (tckFall_q && state_q == SH_DR) begin
        tdo_q <= dr_q[0];
      end else if (tckFall_q && state_q == SH_IR) begin
        tdo_q <= irShift_q[0];
      end
    end
  end

  // A response landing in the same clk as an update frees the slot for the new request.
  assign accessUpd  = updDr && (ir_q == IR_ACCESS);
  assign rspDone    = bus.rsp_valid && busy_q;
  assign busyEff    = busy_q && !rspDone;
  assign issueReq   = accessUpd && !busyEff && (dr_q[66:65] != 2'd3);
  assign badSize    = accessUpd && !busyEff && (dr_q[66:65] == 2'd3);
  assign overrunSet = accessUpd && busyEff;

  always_ff @(posedge clk) begin
    if (reset) begin
      reqValid_q  <= 1'b0;
      reqWr_q     <= 1'b0;
      reqSize_q   <= 2'd0;
      reqAddr_q   <= 32'd0;
      reqWdata_q  <= 32'd0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      overrun_q   <= 1'b0;
      lastRdata_q <= 32'd0;
      lastAddr_q  <= 32'd0;
    end else begin
      if (reqValid_q && bus.req_ready) begin
        reqValid_q <= 1'b0;
      end
      if (rspDone) begin
        busy_q      <= 1'b0;
        lastRdata_q <= bus.rsp_rdata;
        err_q       <= bus.rsp_err;
      end
      if (issueReq) begin
        reqValid_q <= 1'b1;
        reqSize_q  <= dr_q[66:65];
        reqWr_q    <= dr_q[64];
        reqWdata_q <= dr_q[63:32];
        reqAddr_q  <= dr_q[31:0];
        lastAddr_q <= dr_q[31:0];
        busy_q     <= 1'b1;
      end
      if (badSize) begin
        err_q <= 1'b1;
      end
      if (overrunSet) begin
        overrun_q <= 1'b1;
      end else if (overrunClr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign tdo           = tdo_q;
  assign bus.req_valid = reqValid_q;
  assign bus.req_wr    = reqWr_q;
  assign bus.req_size  = reqSize_q;
  assign bus.req_addr  = reqAddr_q;
  assign bus.req_wdata = reqWdata_q;

endmodule

// File: tb/tb_jtag_tap_rsp.sv
// Randomized bench for jtag_tap_rsp: drives the JTAG pins bit by bit, plays the bus
// target, and compares readouts and requests against a register-level model.
module tb_jtag_tap_rsp;

  localparam logic [31:0] ExpIdcode = 32'h1BA0_C001;
  localparam logic [3:0]  IrIdcode  = 4'b0001;
  localparam logic [3:0]  IrAccess  = 4'b0010;
  localparam logic [3:0]  IrStatus  = 4'b0011;
  localparam logic [3:0]  IrBypass  = 4'b1111;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic clk = 1'b0;
  logic reset, tck, tms, tdi, jtrst;
  logic tdo;

  jtag_tap_rsp_if bus ();

  jtag_tap_rsp #(.IDCODE(ExpIdcode), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .tck   (tck),
    .tms   (tms),
    .tdi   (tdi),
    .jtrst (jtrst),
    .tdo   (tdo),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  // Knobs owned by the main sequence, read by the bus target.
  logic        autoRsp, stallReady, forceRsp;
  logic [31:0] forceRdata;
  int          fixedWait;

  // Observations owned by the bus target.
  req_t        seenArr [0:63];
  logic [31:0] rspRdataArr [0:63];
  logic        rspErrArr [0:63];
  int          seenCount, rspCount, unstableCount, dropLateCount, abortCount;
  logic        rspPending;

  // Model of the responder's visible registers.
  logic        mBusy, mErr, mOverrun;
  logic [31:0] mLastAddr, mLastRdata;
  int          mIssued, mRspExp;

  task automatic checkOutput(input string tag, input logic [66:0] actual, input logic [66:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // One TCK period; tdo is sampled just before the rising edge, as an initiator would.
  task automatic applyStimulus(input logic tmsBit, input logic tdiBit, output logic tdoBit);
    tdoBit = tdo;
    tms = tmsBit;
    tdi = tdiBit;
    repeat (2) @(negedge clk);
    tck = 1'b1;
    repeat (5) @(negedge clk);
    tck = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic shiftIr(input logic [3:0] val);
    logic o;
    logic [3:0] cap;
    applyStimulus(1'b1, 1'b0, o);
    applyStimulus(1'b1, 1'b0, o);
    applyStimulus(1'b0, 1'b0, o);
    applyStimulus(1'b0, 1'b0, o);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i == 3, val[i], o);
      cap[i] = o;
    end
    applyStimulus(1'b1, 1'b0, o);
    applyStimulus(1'b0, 1'b0, o);
    checkOutput("irCapture", 67'(cap), 67'(4'b0101));
  endtask

  task automatic shiftDr(input int n, input logic [66:0] din, output logic [66:0] dout);
    logic o;
    dout = '0;
    applyStimulus(1'b1, 1'b0, o);
    applyStimulus(1'b0, 1'b0, o);
    applyStimulus(1'b0, 1'b0, o);
    for (int i = 0; i < n; i++) begin
      applyStimulus(i == n - 1, din[i], o);
      dout[i] = o;
    end
    applyStimulus(1'b1, 1'b0, o);
    applyStimulus(1'b0, 1'b0, o);
  endtask

  task automatic waitReqs(input int target);
    int n = 0;
    while (seenCount < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reqSeen", 67'(seenCount), 67'(target));
  endtask

  task automatic waitRsps(input int target);
    int n = 0;
    while (rspCount < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rspSeen", 67'(rspCount), 67'(target));
  endtask

  task automatic finishRsp();
    mRspExp++;
    waitRsps(mRspExp);
    mBusy      = 1'b0;
    mLastRdata = rspRdataArr[mRspExp-1];
    mErr       = rspErrArr[mRspExp-1];
  endtask

  task automatic doAccess(input logic [1:0] sz, input logic wr, input logic [31:0] data,
                          input logic [31:0] addr, input logic waitRsp);
    logic [66:0] din, dout, expCap;
    logic issue;
    req_t want;
    din    = {sz, wr, data, addr};
    expCap = {2'b00, mErr, mLastRdata, mLastAddr};
    issue  = !mBusy && (sz != 2'd3);
    if (mBusy) mOverrun = 1'b1;
    else if (sz == 2'd3) mErr = 1'b1;
    shiftDr(67, din, dout);
    checkOutput("accessCapture", dout, expCap);
    if (issue) begin
      mBusy     = 1'b1;
      mLastAddr = addr;
      mIssued++;
      waitReqs(mIssued);
      want = '{wr: wr, size: sz, addr: addr, wdata: data};
      checkOutput("reqFields", 67'(seenArr[mIssued-1]), 67'(want));
      if (waitRsp) finishRsp();
    end else begin
      repeat (30) @(negedge clk);
      checkOutput("noReq", 67'(seenCount), 67'(mIssued));
    end
  endtask

  task automatic doStatus();
    logic [66:0] dout;
    shiftIr(IrStatus);
    shiftDr(3, 67'($urandom_range(0, 7)), dout);
    checkOutput("status", 67'(dout[2:0]), 67'({mOverrun, mErr, mBusy}));
    mOverrun = 1'b0;
  endtask

  task automatic checkIdcode(input string tag);
    logic [66:0] dout;
    shiftDr(32, 67'(32'hA5A5_A5A5), dout);
    checkOutput(tag, dout, 67'(ExpIdcode));
  endtask

  task automatic modelReset();
    mBusy = 1'b0; mErr = 1'b0; mOverrun = 1'b0;
    mLastAddr = 32'd0; mLastRdata = 32'd0;
  endtask

  // Bus target: random ready delay, stability watch, optional randomized response.
  initial begin : busTarget
    req_t cur;
    int waitN, n;
    logic aborted;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = 32'd0;
    bus.rsp_err   = 1'b0;
    seenCount = 0; rspCount = 0; unstableCount = 0; dropLateCount = 0; abortCount = 0;
    rspPending = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.req_valid === 1'b1) begin
        cur = '{wr: bus.req_wr, size: bus.req_size, addr: bus.req_addr, wdata: bus.req_wdata};
        if (seenCount < 64) seenArr[seenCount] = cur;
        seenCount++;
        waitN = (fixedWait >= 0) ? fixedWait : int'($urandom_range(0, 4));
        n = 0;
        aborted = 1'b0;
        while (!aborted && n < 3000 && (n < waitN || stallReady)) begin
          @(negedge clk);
          n++;
          if (bus.req_valid !== 1'b1) aborted = 1'b1;
          else if ({bus.req_wr, bus.req_size, bus.req_addr, bus.req_wdata} !== cur) unstableCount++;
        end
        if (aborted) begin
          abortCount++;
        end else begin
          bus.req_ready = 1'b1;
          @(negedge clk);
          bus.req_ready = 1'b0;
          if (bus.req_valid !== 1'b0) dropLateCount++;
          rspPending = 1'b1;
        end
      end else if (rspPending && autoRsp) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        bus.rsp_rdata = forceRsp ? forceRdata : $urandom;
        bus.rsp_err   = forceRsp ? 1'b0 : 1'($urandom_range(0, 1));
        if (rspCount < 64) begin
          rspRdataArr[rspCount] = bus.rsp_rdata;
          rspErrArr[rspCount]   = bus.rsp_err;
        end
        bus.rsp_valid = 1'b1;
        @(negedge clk);
        bus.rsp_valid = 1'b0;
        rspCount++;
        rspPending = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainSeq
    logic o;
    logic [66:0] din, dout;
    autoRsp = 1'b1; stallReady = 1'b0; forceRsp = 1'b0; forceRdata = 32'd0; fixedWait = -1;
    mIssued = 0; mRspExp = 0;
    modelReset();
    reset = 1'b1; tck = 1'b0; tms = 1'b1; tdi = 1'b0; jtrst = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("rstTdo",   67'(tdo), 67'(0));
    checkOutput("rstValid", 67'(bus.req_valid), 67'(0));
    checkOutput("rstWr",    67'(bus.req_wr), 67'(0));
    checkOutput("rstSize",  67'(bus.req_size), 67'(0));
    checkOutput("rstAddr",  67'(bus.req_addr), 67'(0));
    checkOutput("rstWdata", 67'(bus.req_wdata), 67'(0));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] jtrst pulse and IDCODE readout");
    jtrst = 1'b0;
    repeat (6) @(negedge clk);
    jtrst = 1'b1;
    repeat (6) @(negedge clk);
    applyStimulus(1'b0, 1'b0, o);
    checkIdcode("idcodeDefault");
    shiftIr(IrIdcode);
    checkIdcode("idcodeSelected");
    doStatus();

    $display("[TB] directed write with held-off ready");
    shiftIr(IrAccess);
    fixedWait = 5;
    doAccess(2'd2, 1'b1, 32'h0000_0200, 32'h0000_0000, 1'b1);
    fixedWait = -1;
    checkOutput("stableHold", 67'(unstableCount), 67'(0));
    checkOutput("dropAfterAccept", 67'(dropLateCount), 67'(0));

    $display("[TB] directed read and capture");
    forceRsp = 1'b1;
    forceRdata = 32'hDEAD_BEEF;
    doAccess(2'd2, 1'b0, 32'h0, 32'h0000_0040, 1'b1);
    doAccess(2'd0, 1'b0, 32'h0, 32'h0000_0000, 1'b1);
    doStatus();

    $display("[TB] overrun and reserved size");
    shiftIr(IrAccess);
    autoRsp = 1'b0;
    doAccess(2'd2, 1'b1, $urandom, $urandom, 1'b0);
    doAccess(2'd1, 1'b1, $urandom, $urandom, 1'b0);
    doStatus();
    doStatus();
    autoRsp = 1'b1;
    finishRsp();
    shiftIr(IrAccess);
    doAccess(2'd3, 1'b1, $urandom, $urandom, 1'b1);
    doStatus();
    forceRsp = 1'b0;

    $display("[TB] randomized ACCESS traffic");
    shiftIr(IrAccess);
    for (int k = 0; k < 12; k++) begin
      doAccess(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, $urandom, 1'b1);
    end
    doStatus();

    $display("[TB] TLR from ShDR and bypass");
    shiftIr(IrStatus);
    applyStimulus(1'b1, 1'b0, o);
    applyStimulus(1'b0, 1'b0, o);
    applyStimulus(1'b0, 1'b0, o);
    mOverrun = 1'b0;
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, o);
    applyStimulus(1'b0, 1'b0, o);
    checkIdcode("idcodeAfterTlr");
    shiftIr(IrBypass);
    din = 67'($urandom_range(0, 255));
    shiftDr(8, din, dout);
    checkOutput("bypass", dout, 67'({din[6:0], 1'b0}));

    $display("[TB] jtrst during an outstanding request");
    shiftIr(IrAccess);
    stallReady = 1'b1;
    doAccess(2'd2, 1'b1, $urandom, $urandom, 1'b0);
    jtrst = 1'b0;
    repeat (8) @(negedge clk);
    jtrst = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("reqHeldJtrst", 67'(bus.req_valid), 67'(1));
    stallReady = 1'b0;
    finishRsp();
    applyStimulus(1'b0, 1'b0, o);
    checkIdcode("idcodeAfterJtrst");

    $display("[TB] reset during an outstanding request");
    shiftIr(IrAccess);
    stallReady = 1'b1;
    doAccess(2'd2, 1'b0, 32'h0, $urandom, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reqDropReset", 67'(bus.req_valid), 67'(0));
    reset = 1'b0;
    stallReady = 1'b0;
    modelReset();
    repeat (4) @(negedge clk);
    checkOutput("abortSeen", 67'(abortCount), 67'(1));
    applyStimulus(1'b0, 1'b0, o);
    doStatus();

    repeat (20) @(negedge clk);
    checkOutput("finalReqCount", 67'(seenCount), 67'(mIssued));
    checkOutput("finalRspCount", 67'(rspCount), 67'(mRspExp));
    checkOutput("finalStable", 67'(unstableCount), 67'(0));
    checkOutput("finalDrop", 67'(dropLateCount), 67'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/jtag_tap_rsp.md
# jtag_tap_rsp

Synthesizable JTAG TAP responder: the target end of the TCK/TMS/TDI/TDO link driven by the verification JTAG initiator. It oversamples the JTAG pins in the system clock domain, runs the IEEE 1149.1 16-state TAP controller, and decodes a 4-bit IR that selects one of four data registers. A 67-bit ACCESS register is turned into single-beat bus requests on a valid/ready port, and the bus result is captured back for readout. It sits between the chip JTAG pads and the debug bus fabric.

## Interface
- IDCODE, 32'h1BA0_C001, value captured into the IDCODE DR
- SYNC_STAGES, 2, synchronizer depth on tck/tms/tdi/jtrst (≥2)
- clk  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- tck  in  1  JTAG test clock (asynchronous, oversampled)
- tms  in  1  test mode select
- tdi  in  1  test data in
- jtrst  in  1  JTAG reset, active-low, synchronized then applied synchronously
- tdo  out  1  test data out
- req_valid  out  1  bus request valid
- req_ready  in  1  bus accepts request
- req_wr  out  1  1 = write, 0 = read
- req_size  out  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- req_addr  out  32  byte address
- req_wdata  out  32  write data
- rsp_valid  in  1  single-cycle bus completion strobe
- rsp_rdata  in  32  read data, valid with rsp_valid
- rsp_err  in  1  bus error, valid with rsp_valid

## Operation
- Pin sampling: tck, tms, tdi and jtrst each pass through SYNC_STAGES flops. One more flop of synced tck gives tck_rise (0→1) and tck_fall (1→0) single-clk strobes.
- TAP FSM: the standard 16 states (TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR, and the same set for IR). It advances only on tck_rise, using synced tms. TLR is entered on reset, on synced jtrst = 0, or after 5 consecutive tms = 1 rises.
- IR: 4 bits. CapIR loads 4'b0101. In ShIR, each tck_rise shifts tdi into the MSB and out of the LSB. UpdIR commits the value. TLR sets IR = 4'b0001.
- IR decode:
  - 0001 IDCODE: 32 bits; CapDR loads IDCODE.
  - 0010 ACCESS: 67 bits, LSB first, {size[66:65], wr[64], data[63:32], addr[31:0]}. CapDR loads {2'b00, err, last_rdata, last_addr}.
  - 0011 STATUS: 3 bits {overrun, err, busy}. CapDR clears overrun.
  - Any other value is BYPASS: 1 bit, CapDR loads 0.
- Shifting: shift occurs on every tck_rise while the FSM is in ShDR/ShIR, including the rise that exits to Ex1. The register shifts right with tdi entering at the MSB.
- tdo: updated on tck_fall to the selected register's LSB while in ShDR/ShIR; otherwise it holds its value.
- UpdDR with ACCESS:
  - busy = 0: latch the fields onto req_*, assert req_valid, set busy, record last_addr.
  - busy = 1: no request is issued; set sticky overrun.
- Bus handshake:
  - req_valid stays high, with req_* stable, until the clk where req_valid & req_ready; it drops the next clk.
  - busy clears on rsp_valid; rsp_rdata is latched into last_rdata and rsp_err into err.
  - A size = 3 request is not issued: err = 1 is set directly and busy does not set.
  - rsp_valid while busy = 0 is ignored.
- TAP reset (jtrst or TLR) does not abort an outstanding bus transaction. busy, req_* and the response capture continue. Only reset clears the bus side.

## Timing
- Reset values:
  - outputs: tdo = 0, req_valid = 0, req_wr = 0, req_size = 0, req_addr = 0, req_wdata = 0
  - internal: FSM = TLR, IR = 0001, busy/err/overrun = 0, last_rdata/last_addr = 0
- Edge latency: pin tck edge → tck_rise/tck_fall strobe is SYNC_STAGES+1 clk.
- TDO latency: tdo changes 1 clk after the tck_fall strobe.
- Minimum tck high time and low time: each ≥ SYNC_STAGES+2 clk. tms/tdi must be stable at least 1 clk before the tck rise and held until tck falls.
- Request latency: req_valid asserts 1 clk after the tck_rise that enters UpdDR.
- Simultaneous events:
  - rsp_valid in the same clk as an UpdDR issue: the response completes first, then the new request issues (no overrun).
  - reset has priority over all else.

## Test plan
- jtrst pulse, then IR = 0001 and a 32-bit DR shift of 0xA5A5A5A5 → tdo bits reassemble to 0x1BA0C001; IR capture shifts out 0101.
- IR = 0010, shift {2'b10, 1, 0x0000_0200, 0x0000_0000} → one req_valid with wr = 1, size = 2, addr = 0, wdata = 0x200. With req_ready held low for 5 clk, req_* stay stable and req_valid drops 1 clk after acceptance.
- Read of addr 0x40 with rsp_rdata = 0xDEADBEEF, then a second ACCESS capture → shifted-out bits [63:32] = 0xDEADBEEF and [31:0] = 0x40; STATUS reads 000.
- Second UpdDR while busy (rsp withheld) → no second req_valid; STATUS = 101 (overrun, busy), next STATUS capture shows overrun = 0. size = 3 request → no req_valid and err = 1.
- Five tms = 1 rises from ShDR → FSM in TLR and IR = 0001. An unknown IR of 1111 → 1-bit bypass, so tdo lags tdi by exactly one tck.
- reset asserted while req_valid = 1 → req_valid = 0 and busy = 0 on the next clk; jtrst alone mid-request leaves req_valid asserted until accepted.
